// File: rtl/pdecode_seq.sv
// pdecode_seq: collects a frame of 3-bit code beats, ORs their decoded masks
// together and presents one result per frame (mask, beat count and a flag for
// codes that added no new bits) through a valid/ready output handshake.
module pdecode_seq #(
    parameter int THERMO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_mask,
    output logic [3:0] out_cnt,
    output logic       out_dup,
    input  logic       out_ready
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Code-to-mask decode. The thermometer form ~(8'hFE << k) equals
    // (9'd1 << (k+1)) - 1 truncated to 8 bits, so k=7 yields 8'hFF.
    function automatic logic [7:0] dec(input logic [2:0] k);
        logic [7:0] m;
        if (THERMO != 0) begin
            m = ~(8'hFE << k);
        end else begin
            m = 8'h01 << k;
        end
        return m;
    endfunction

    state_t     state_r;
    logic [7:0] acc_r;
    logic [3:0] cnt_r;
    logic       dup_r;

    logic [7:0] dec_s;
    logic       beat_s;
    logic [7:0] acc_nxt_s;
    logic [3:0] cnt_nxt_s;
    logic       dup_nxt_s;

    // Accepting whenever idle-accumulating; blocked while a result is held.
    assign in_ready = (state_r == ACCUM);

    // Next accumulator values for a beat taken this cycle.
    always_comb begin
        dec_s     = dec(in_code);
        beat_s    = in_valid && (state_r == ACCUM);
        acc_nxt_s = acc_r | dec_s;
        cnt_nxt_s = (cnt_r == 4'd15) ? 4'd15 : (cnt_r + 4'd1);
        dup_nxt_s = dup_r | ((acc_r & dec_s) == dec_s);
    end

    // Frame FSM: accumulate beats, publish on last beat, hold until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ACCUM;
            acc_r     <= 8'h00;
            cnt_r     <= 4'd0;
            dup_r     <= 1'b0;
            out_valid <= 1'b0;
            out_mask  <= 8'h00;
            out_cnt   <= 4'd0;
            out_dup   <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (beat_s) begin
                        if (in_last) begin
                            out_mask  <= acc_nxt_s;
                            out_cnt   <= cnt_nxt_s;
                            out_dup   <= dup_nxt_s;
                            out_valid <= 1'b1;
                            acc_r     <= 8'h00;
                            cnt_r     <= 4'd0;
                            dup_r     <= 1'b0;
                            state_r   <= HOLD;
                        end else begin
                            acc_r <= acc_nxt_s;
                            cnt_r <= cnt_nxt_s;
                            dup_r <= dup_nxt_s;
                        end
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= ACCUM;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_r   <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdecode_seq.sv
// Bench for pdecode_seq: runs a one-hot and a thermometer instance on the same
// stimulus and compares both against a frame-level reference model.
module tb_pdecode_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_last;
    logic       out_ready;

    logic       in_ready0, in_ready1;
    logic       out_valid0, out_valid1;
    logic [7:0] out_mask0, out_mask1;
    logic [3:0] out_cnt0, out_cnt1;
    logic       out_dup0, out_dup1;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    bit         m_hold;
    bit         m_valid;
    logic [7:0] m_mask [2];
    int         m_cnt;
    bit         m_dup [2];
    int         frame [$];

    always #5 clk = ~clk;

    pdecode_seq #(.THERMO(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
        .in_last(in_last), .in_ready(in_ready0), .out_valid(out_valid0),
        .out_mask(out_mask0), .out_cnt(out_cnt0), .out_dup(out_dup0),
        .out_ready(out_ready)
    );

    pdecode_seq #(.THERMO(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
        .in_last(in_last), .in_ready(in_ready1), .out_valid(out_valid1),
        .out_mask(out_mask1), .out_cnt(out_cnt1), .out_dup(out_dup1),
        .out_ready(out_ready)
    );

    function automatic int ref_dec(int thermo, int k);
        if (thermo != 0) return (1 << (k + 1)) - 1;
        else return 1 << k;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold  = 1'b0;
        m_valid = 1'b0;
        m_cnt   = 0;
        for (int t = 0; t < 2; t++) begin
            m_mask[t] = 8'h00;
            m_dup[t]  = 1'b0;
        end
        frame.delete();
    endtask

    task automatic finish_frame();
        for (int t = 0; t < 2; t++) begin
            int  seen;
            bit  dup;
            seen = 0;
            dup  = 1'b0;
            foreach (frame[i]) begin
                int d;
                d = ref_dec(t, frame[i]);
                if ((seen & d) == d) dup = 1'b1;
                seen = seen | d;
            end
            m_mask[t] = 8'(seen);
            m_dup[t]  = dup;
        end
        m_cnt   = (frame.size() > 15) ? 15 : frame.size();
        m_hold  = 1'b1;
        m_valid = 1'b1;
        frame.delete();
    endtask

    task automatic check_all(string tag);
        check({tag, ".in_ready0"},  32'(in_ready0),  32'(!m_hold));
        check({tag, ".in_ready1"},  32'(in_ready1),  32'(!m_hold));
        check({tag, ".out_valid0"}, 32'(out_valid0), 32'(m_valid));
        check({tag, ".out_valid1"}, 32'(out_valid1), 32'(m_valid));
        check({tag, ".out_mask0"},  32'(out_mask0),  32'(m_mask[0]));
        check({tag, ".out_mask1"},  32'(out_mask1),  32'(m_mask[1]));
        check({tag, ".out_cnt0"},   32'(out_cnt0),   32'(m_cnt));
        check({tag, ".out_cnt1"},   32'(out_cnt1),   32'(m_cnt));
        check({tag, ".out_dup0"},   32'(out_dup0),   32'(m_dup[0]));
        check({tag, ".out_dup1"},   32'(out_dup1),   32'(m_dup[1]));
    endtask

    // One clock edge with the current inputs; returns whether a beat transferred.
    task automatic cycle(output bit accepted);
        accepted = in_valid && !m_hold;
        if (m_hold) begin
            if (out_ready) begin
                m_hold  = 1'b0;
                m_valid = 1'b0;
            end
        end else if (in_valid) begin
            frame.push_back(int'(in_code));
            if (in_last) finish_frame();
        end
        @(posedge clk);
        #1;
        check_all("step");
    endtask

    task automatic idle();
        bit a;
        cycle(a);
    endtask

    task automatic beat(int code, bit last);
        bit a;
        in_valid = 1'b1;
        in_code  = 3'(code);
        in_last  = last;
        cycle(a);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        bit acc_last;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 3'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_reset();
        #2;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // one-hot frame 3,5,0 -> 8'h29, consumed next cycle
        beat(3, 1'b0);
        beat(5, 1'b0);
        beat(0, 1'b1);
        check("r28.mask", 32'(out_mask0), 32'h29);
        check("r28.cnt",  32'(out_cnt0),  32'd3);
        check("r28.valid", 32'(out_valid0), 32'd1);
        idle();
        check("r28.drop", 32'(out_valid0), 32'd0);

        // thermometer frames 2,6 and 6,2
        beat(2, 1'b0);
        beat(6, 1'b1);
        check("r29a.mask", 32'(out_mask1), 32'h7F);
        check("r29a.dup",  32'(out_dup1),  32'd0);
        idle();
        beat(6, 1'b0);
        beat(2, 1'b1);
        check("r29b.mask", 32'(out_mask1), 32'h7F);
        check("r29b.dup",  32'(out_dup1),  32'd1);
        idle();

        // backpressure: result held while a new beat is offered
        out_ready = 1'b0;
        beat(7, 1'b1);
        check("r30.mask", 32'(out_mask0), 32'h80);
        in_valid = 1'b1;
        in_code  = 3'd3;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(acc_last);
            check("r30.stable", 32'(out_mask0), 32'h80);
        end
        out_ready = 1'b1;
        cycle(acc_last);
        check("r30.ready", 32'(in_ready0), 32'd1);
        cycle(acc_last);
        check("r30.newmask", 32'(out_mask0), 32'h08);
        in_valid = 1'b0;
        in_last  = 1'b0;
        idle();

        // long frame saturates count
        for (int i = 0; i < 16; i++) beat(1, 1'b0);
        beat(1, 1'b1);
        check("r31.cnt",  32'(out_cnt0),  32'd15);
        check("r31.mask", 32'(out_mask0), 32'h02);
        check("r31.dup",  32'(out_dup0),  32'd1);
        idle();

        // reset mid-frame discards partial frame
        beat(4, 1'b0);
        beat(4, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("r32.rst");
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        beat(1, 1'b1);
        check("r32.mask", 32'(out_mask0), 32'h02);
        check("r32.cnt",  32'(out_cnt0),  32'd1);
        check("r32.dup",  32'(out_dup0),  32'd0);

        // reset while holding a result clears it without a clock edge
        rst = 1'b1;
        #1;
        model_reset();
        check_all("r33.rst");
        check("r33.mask", 32'(out_mask0), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // randomized traffic; producer keeps an unaccepted beat stable
        acc_last = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc_last) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_code  = 3'($urandom_range(0, 7));
                in_last  = ($urandom_range(0, 9) == 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            cycle(acc_last);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pdecode_seq.md
PDECODE_SEQ -- requirements
Module: pdecode_seq

Interface
REQ-001 Parameter THERMO, default 0: 0 = one-hot decode; 1 = thermometer decode, i.e. code k sets bits k..0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  code beat offered.
REQ-005 in_code  input  3  code value 0..7.
REQ-006 in_last  input  1  beat is last of frame; qualified by in_valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 out_valid  output  1  frame result pending.
REQ-009 out_mask  output  8  decoded frame mask.
REQ-010 out_cnt  output  4  beats in frame, saturating at 15.
REQ-011 out_dup  output  1  frame contained a code whose decoded bits were already all set.
REQ-012 out_ready  input  1  consumer accepts the result.

Function
REQ-013 Two states: ACCUM and HOLD; in_ready SHALL be 1 exactly when state is ACCUM (combinational from state).
REQ-014 A beat transfers when in_valid && in_ready; nothing else may change the accumulator.
REQ-015 dec(k): THERMO=0 -> 8'b1 << k; THERMO=1 -> (8'b1 << (k+1)) - 1, computed 9 bits wide so k=7 gives 8'hFF.
REQ-016 ACCUM, beat with in_last=0: acc <= acc | dec(in_code); cnt <= min(cnt+1, 15); dup <= dup | ((acc & dec(in_code)) == dec(in_code)).
REQ-017 ACCUM, beat with in_last=1:
- out_mask <= acc | dec(in_code); out_cnt <= min(cnt+1, 15); out_dup <= updated dup term.
- out_valid <= 1; acc, cnt and dup cleared to 0; next state HOLD.
- Result visible the cycle after the last beat (latency 1).
REQ-018 HOLD: out_mask, out_cnt and out_dup SHALL remain stable while out_valid && !out_ready.
REQ-019 HOLD with out_ready=1: out_valid <= 0; next state ACCUM; the next beat is accepted no earlier than the following cycle.
REQ-020 A single-beat frame (first beat has in_last=1) SHALL produce out_cnt=1, out_dup=0, out_mask=dec(code).
REQ-021 out_valid=0 in ACCUM: out_mask, out_cnt and out_dup hold the previous frame's values; consumers ignore them.
REQ-022 Beats offered in HOLD are not accepted; the producer must hold in_valid, in_code and in_last until in_ready=1.
REQ-023 in_valid=0 in ACCUM: no state change; a partial frame persists indefinitely.
REQ-024 Saturation: out_cnt stays at 15 for frames longer than 15 beats; acc and dup keep updating.

Reset
REQ-025 While rst=1: state=ACCUM; acc=0, cnt=0, dup=0; out_valid=0, out_mask=8'h00, out_cnt=0, out_dup=0; in_ready=1.
REQ-026 rst asserted mid-frame or in HOLD SHALL discard the partial frame or pending result immediately, without waiting for a clock edge.
REQ-027 The first beat after rst deasserts starts a new frame.

Verification
REQ-028 THERMO=0, beats 3, 5, 0(last), out_ready=1 -> one cycle after last beat: out_valid=1, out_mask=8'h29, out_cnt=3, out_dup=0; out_valid=0 on the next cycle.
REQ-029 THERMO=1, beats 2, 6(last) -> out_mask=8'h7F, out_cnt=2, out_dup=0; beats 6, 2(last) -> out_mask=8'h7F, out_dup=1.
REQ-030 Backpressure: frame 7(last) with out_ready=0 for 5 cycles -> out_mask=8'h80 stable, in_ready=0, held in_valid beats not accepted; out_ready=1 -> out_valid drops, in_ready=1 the next cycle.
REQ-031 THERMO=0, 17 beats of code 1, last on beat 17 -> out_cnt=15, out_mask=8'h02, out_dup=1.
REQ-032 Reset mid-frame: beats 4, 4, then rst pulse, then beat 1(last) -> out_mask=8'h02, out_cnt=1, out_dup=0.
REQ-033 Reset in HOLD with out_valid=1 -> out_valid=0 and out_mask=8'h00 without a clock edge; in_ready=1.
